if_stage: RTL

- Fetch stage; receiving end of the pre-IF instruction request path.
- Pairs each pre-IF pc/valid with the inst_sram read data returned one cycle after that address was issued.
- Queues {pc, inst, adef} in a small FIFO and presents it to ID with a valid/allowin handshake.
- Drives the stall back to pre-IF; drops wrong-path words on branch, exception or ertn flush.

---
 rtl/if_stage.sv | 106 ++++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage.
// Pairs each pre-IF pc/valid with the inst_sram word returned one cycle after
// the address was issued, queues {pc, inst, adef} and hands the head to ID
// through a valid/allowin handshake. Wrong-path words are dropped on any flush.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   pfs_valid/pc/excp_adef   pre-IF pc register and its misalignment flag
//   inst_sram_rdata       read data for pfs_pc (1-cycle SRAM latency)
//   br_taken_cancel, excp_flush, ertn_flush   redirects (any one flushes)
//   ds_allowin            ID accepts the head entry this cycle
//   stall                 to pre-IF: hold pc and re-issue the same address
//   fs_to_ds_valid, fs_pc, fs_inst, fs_excp_adef   head entry to ID
module if_stage #(
   parameter int unsigned DEPTH      = 2,
   parameter logic [31:0] RESET_INST = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pfs_valid,
   input  logic [31:0] pfs_pc,
   input  logic        pfs_excp_adef,
   input  logic [31:0] inst_sram_rdata,
   input  logic        br_taken_cancel,
   input  logic        excp_flush,
   input  logic        ertn_flush,
   input  logic        ds_allowin,
   output logic        stall,
   output logic        fs_to_ds_valid,
   output logic [31:0] fs_pc,
   output logic [31:0] fs_inst,
   output logic        fs_excp_adef
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic             adef_block;

   logic [31:0]      pc_mem   [DEPTH];
   logic [31:0]      inst_mem [DEPTH];
   logic [DEPTH-1:0] adef_mem;

   logic flush;
   logic push;
   logic pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Handshake terms; stall comes from count only so it has no path from ID or flush.
   assign flush = br_taken_cancel | excp_flush | ertn_flush;
   assign stall = (count == CNT_W'(DEPTH));
   assign push  = pfs_valid & ~stall & ~adef_block & ~flush;
   assign pop   = fs_to_ds_valid & ds_allowin & ~flush;

   // Queue control: pointers, occupancy and the post-ADEF fetch block.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         adef_block <= 1'b0;
      end else if (flush) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         adef_block <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (push && pfs_excp_adef) begin
            adef_block <= 1'b1;
         end
      end
   end

   // Entry storage; a faulting pc never carries fetched data.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]   <= pfs_pc;
         inst_mem[wr_ptr] <= pfs_excp_adef ? RESET_INST : inst_sram_rdata;
         adef_mem[wr_ptr] <= pfs_excp_adef;
      end
   end

   // Head read; masked to reset values while empty.
   assign fs_to_ds_valid = (count != '0);
   assign fs_pc          = fs_to_ds_valid ? pc_mem[rd_ptr]   : 32'h0;
   assign fs_inst        = fs_to_ds_valid ? inst_mem[rd_ptr] : RESET_INST;
   assign fs_excp_adef   = fs_to_ds_valid & adef_mem[rd_ptr];

endmodule
